xor_share_arbiter: RTL and testbench
====================================

XOR_SHARE_ARBITER -- requirements
Module: xor_share_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 Requester count SHALL be fixed at 4; requester ID width fixed at 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  4  per-requester operation request, bit i = requester i.
REQ-006 req_a  input  4*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  4*WIDTH  operand B; same packing as req_a.
REQ-008 req_ready  output  4  per-requester acceptance; accept = req_valid[i] & req_ready[i].
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_data  output  WIDTH  req_a XOR req_b of the accepted request.
REQ-011 rsp_id  output  2  index of the requester that owns rsp_data.
REQ-012 rsp_ready  input  1  consumer accepts result; handshake = rsp_valid & rsp_ready.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Compute SHALL use exactly one instance of the existing 1-bit xor_gate, time-shared bit-serially; no wide XOR operator on the operands.
REQ-015 FSM states: IDLE, SHIFT, RESP; no other reachable states.
REQ-016 IDLE: if any req_valid bit is set, grant one requester round-robin, searching from last_grant+1 mod 4 upward; else remain in IDLE.
REQ-017 req_ready SHALL be combinational: high only for the granted index, only in IDLE; all bits 0 in SHIFT and RESP; independent of rsp_ready.
REQ-018 On acceptance: capture the granted req_a/req_b into shift registers, the index into rsp_id, clear the bit counter, set last_grant to the granted index, and move to SHIFT.
REQ-019 SHIFT: each cycle, feed operand LSBs to xor_gate, shift the result bit into the result register from the MSB side, shift both operand registers right by 1, and increment the counter.
REQ-020 SHIFT SHALL last exactly WIDTH cycles, then move to RESP; the result register then holds req_a XOR req_b with bit 0 at LSB.
REQ-021 Latency: acceptance edge at cycle T -> rsp_valid first high in cycle T+WIDTH+1.
REQ-022 RESP: rsp_valid=1; rsp_data and rsp_id held stable until handshake; on handshake, move to IDLE.
REQ-023 rsp_data and rsp_id SHALL be 0 whenever rsp_valid=0.
REQ-024 Operand changes on req_a/req_b after acceptance SHALL NOT affect the result.
REQ-025 A requester deasserting req_valid before it is granted SHALL leave no state change.
REQ-026 With all four requesters continuously valid, grants SHALL follow 0,1,2,3,0,...; no requester waits more than 3 other operations.
REQ-027 Throughput with rsp_ready held high: one operation per WIDTH+2 cycles, with no pipelining or overlap.
REQ-028 WIDTH=1: SHIFT lasts 1 cycle; all rules above still hold.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, counter=0, shift and result registers=0.
REQ-030 Reset value of last_grant SHALL be 3, so requester 0 has first priority after reset.
REQ-031 Reset during SHIFT or RESP SHALL abort the operation; no response for it is ever produced.
REQ-032 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-033 Single op: req0 a=8'hA5, b=8'h3C, accepted at cycle T -> rsp_valid at T+9, rsp_data=8'h99, rsp_id=0.
REQ-034 Round-robin: all four valid with (FF,00), (0F,F0), (AA,AA), (12,34), rsp_ready=1 -> responses in ID order 0,1,2,3 with data FF, FF, 00, 26, spaced 10 cycles apart.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id held, req_ready=4'b0000, busy=1; release -> IDLE next cycle.
REQ-036 Reset mid-op: rst_n low in the 4th SHIFT cycle -> all outputs 0 in the same cycle; after release with req3 and req0 both valid -> requester 0 granted first.
REQ-037 Operand stability: change req_a/req_b of the granted requester during SHIFT -> rsp_data equals XOR of the captured values.
REQ-038 Fairness: req2 continuously valid, req0 pulsed valid -> grants alternate between 0 and 2, and neither is skipped.

Source files
------------

// File: rtl/xor_share_arbiter.sv
// Four-way round-robin arbiter feeding a single bit-serial XOR engine.
// One granted request is processed at a time: capture, WIDTH shift cycles, then hold the response.

module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// state | meaning
// IDLE  | waiting for a request; grants one requester round-robin
// SHIFT | serial XOR, one bit per cycle for WIDTH cycles
// RESP  | result presented on rsp_* until the consumer accepts it
module xor_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req_valid,
  input  logic [4*WIDTH-1:0]   req_a,
  input  logic [4*WIDTH-1:0]   req_b,
  output logic [3:0]           req_ready,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [1:0]           rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       last_grant;
  logic [1:0]       gnt_id;
  logic [1:0]       scan_idx;
  logic             gnt_any;
  logic [1:0]       id_q;
  logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
  logic [5:0]       cnt;
  logic             bit_x;
  logic             accept;
  logic             shift_done;

  // Search starts just past the last winner, so every requester gets a turn within four grants.
  always_comb begin
    gnt_id   = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_grant + 2'(k);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_id  = scan_idx;
        gnt_any = 1'b1;
      end
    end
  end

  assign accept     = (state == IDLE) && gnt_any;
  assign shift_done = (cnt == 6'(WIDTH - 1));

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  xor_gate u_xor (
    .a (op_a[0]),
    .b (op_b[0]),
    .y (bit_x)
  );

  // Result bits enter from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_nxt = bit_x;
    end else begin : g_res_wn
      assign res_nxt = {bit_x, res[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any)    state_nxt = SHIFT;
      SHIFT:   if (shift_done) state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd3;
      id_q       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      cnt        <= '0;
    end else if (accept) begin
      last_grant <= gnt_id;
      id_q       <= gnt_id;
      op_a       <= req_a[gnt_id*WIDTH +: WIDTH];
      op_b       <= req_b[gnt_id*WIDTH +: WIDTH];
      cnt        <= '0;
    end else if (state == SHIFT) begin
      res  <= res_nxt;
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
      cnt  <= cnt + 6'd1;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_valid ? res  : '0;
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter at WIDTH=8: latency, round-robin order,
// backpressure, mid-operation reset, operand stability and fairness.

module tb_xor_share_arbiter;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ready;
  logic           busy;

  int checks = 0;
  int errors = 0;

  xor_share_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Steps at least once, then until rsp_valid or the budget runs out.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!rsp_valid && n < 50);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b vld=%b data=%h id=%0d busy=%b, want all 0",
               req_ready, rsp_valid, rsp_data, rsp_id, busy);
    end
    req_valid = 4'b0000;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_op();
    int n;
    rsp_ready = 1'b0;
    set_op(0, 8'hA5, 8'h3C);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    wait_rsp(n);
    req_valid = 4'b0000;
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL single_latency: got %0d want 9", n);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h99 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp: got vld=%b data=%h id=%0d want 1 99 0", rsp_valid, rsp_data, rsp_id);
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL single_done: got vld=%b busy=%b data=%h want 0 0 00", rsp_valid, busy, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [W-1:0] exp_data [4];
    exp_data[0] = 8'hFF; exp_data[1] = 8'hFF; exp_data[2] = 8'h00; exp_data[3] = 8'h26;
    do_reset();
    rsp_ready = 1'b1;
    set_op(0, 8'hFF, 8'h00);
    set_op(1, 8'h0F, 8'hF0);
    set_op(2, 8'hAA, 8'hAA);
    set_op(3, 8'h12, 8'h34);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(n);
      if (i == 3) req_valid = 4'b0000;
      checks++;
      if (n !== (i == 0 ? 9 : 10)) begin
        errors++;
        $display("FAIL rr_spacing_%0d: got %0d want %0d", i, n, (i == 0 ? 9 : 10));
      end
      checks++;
      if (rsp_id !== 2'(i) || rsp_data !== exp_data[i]) begin
        errors++;
        $display("FAIL rr_rsp_%0d: got id=%0d data=%h want id=%0d data=%h", i, rsp_id, rsp_data, i, exp_data[i]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    set_op(1, 8'h5A, 8'h0F);
    req_valid = 4'b0010;
    wait_rsp(n);
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%b data=%h id=%0d ready=%b busy=%b want 1 55 1 0000 1",
                 i, rsp_valid, rsp_data, rsp_id, req_ready, busy);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release: got vld=%b busy=%b ready=%b want 0 0 0001", rsp_valid, busy, req_ready);
    end
    // req0 withdraws before its grant edge: last_grant must remain 1.
    req_valid = 4'b0000;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_busy: got %b want 0", busy);
    end
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL withdraw_next_grant: got %b want 0001", req_ready);
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_op();
    int n;
    rsp_ready = 1'b1;
    set_op(3, 8'hC3, 8'h3C);
    set_op(0, 8'h01, 8'h02);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    step(); step(); step();
    req_valid = 4'b1001;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b vld=%b data=%h id=%0d busy=%b want all 0",
               req_ready, rsp_valid, rsp_data, rsp_id, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_first_grant: got %b want 0001", req_ready);
    end
    wait_rsp(n);
    req_valid = 4'b0000;
    checks++;
    if (n !== 9 || rsp_id !== 2'd0 || rsp_data !== 8'h03) begin
      errors++;
      $display("FAIL midreset_rsp: got lat=%0d id=%0d data=%h want 9 0 03", n, rsp_id, rsp_data);
    end
    step();
  endtask

  task automatic test_operand_stability();
    int n;
    rsp_ready = 1'b1;
    set_op(2, 8'h3C, 8'hA5);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    set_op(2, 8'hFF, 8'h00);
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stab_shift_outputs: got vld=%b data=%h id=%0d busy=%b want 0 00 0 1",
               rsp_valid, rsp_data, rsp_id, busy);
    end
    set_op(2, 8'h00, 8'h00);
    wait_rsp(n);
    checks++;
    if (rsp_data !== 8'h99 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL stab_rsp: got data=%h id=%0d want 99 2", rsp_data, rsp_id);
    end
    step();
  endtask

  task automatic test_fairness();
    int n;
    logic [1:0] exp_id;
    logic [W-1:0] exp_data;
    rsp_ready = 1'b1;
    set_op(0, 8'h01, 8'h10);
    set_op(2, 8'h0F, 8'h01);
    // last winner was 2, so the pulsed req0 wins first, then they alternate.
    for (int i = 0; i < 4; i++) begin
      exp_id   = (i % 2 == 0) ? 2'd0 : 2'd2;
      exp_data = (i % 2 == 0) ? 8'h11 : 8'h0E;
      req_valid = 4'b0101;
      #1;
      checks++;
      if (req_ready !== (4'b0001 << exp_id)) begin
        errors++;
        $display("FAIL fair_ready_%0d: got %b want %b", i, req_ready, 4'b0001 << exp_id);
      end
      step();
      req_valid = 4'b0100;
      wait_rsp(n);
      checks++;
      if (rsp_id !== exp_id || rsp_data !== exp_data) begin
        errors++;
        $display("FAIL fair_rsp_%0d: got id=%0d data=%h want id=%0d data=%h", i, rsp_id, rsp_data, exp_id, exp_data);
      end
      step();
    end
    req_valid = 4'b0000;
    step(); step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_operand_stability();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
